// File: rtl/seg_word_pkg.sv
// rtl/seg_word_pkg.sv - segment patterns, letter codes, expected word and FSM states
package seg_word_pkg;

    localparam int WORD_LEN = 13;

    localparam logic [6:0] PAT_BLANK = 7'b0000000;
    localparam logic [6:0] PAT_S     = 7'b1011011;
    localparam logic [6:0] PAT_E     = 7'b1001111;
    localparam logic [6:0] PAT_N     = 7'b0010101;
    localparam logic [6:0] PAT_O     = 7'b1111110;
    localparam logic [6:0] PAT_L     = 7'b0001110;
    localparam logic [6:0] PAT_G     = 7'b1011111;
    localparam logic [6:0] PAT_U     = 7'b0111110;

    localparam logic [3:0] CODE_BLANK   = 4'h0;
    localparam logic [3:0] CODE_S       = 4'h1;
    localparam logic [3:0] CODE_E       = 4'h2;
    localparam logic [3:0] CODE_N       = 4'h3;
    localparam logic [3:0] CODE_O       = 4'h4;
    localparam logic [3:0] CODE_L       = 4'h5;
    localparam logic [3:0] CODE_G       = 4'h6;
    localparam logic [3:0] CODE_U       = 4'h7;
    localparam logic [3:0] CODE_UNKNOWN = 4'hF;

    localparam logic [3:0] EXP [WORD_LEN] = '{
        CODE_S, CODE_E, CODE_N, CODE_O, CODE_L, CODE_G, CODE_U,
        CODE_L, CODE_G, CODE_O, CODE_N, CODE_U, CODE_L
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } state_e;

    function automatic logic [3:0] decode_seg(input logic [6:0] pat);
        logic [3:0] code;
        case (pat)
            PAT_BLANK: code = CODE_BLANK;
            PAT_S:     code = CODE_S;
            PAT_E:     code = CODE_E;
            PAT_N:     code = CODE_N;
            PAT_O:     code = CODE_O;
            PAT_L:     code = CODE_L;
            PAT_G:     code = CODE_G;
            PAT_U:     code = CODE_U;
            default:   code = CODE_UNKNOWN;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// rtl/seg_stable_filter.sv - input register and run-length glitch filter
module seg_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic       accept,
    output logic [6:0] pattern
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic [7:0] run_len_q;
    logic [7:0] run_len_d;
    logic       changed;

    // accept is combinational so the consumer registers it on the same edge
    // where run_len reaches the window; the saturated run never re-fires.
    always_comb begin
        seg_d   = seg_in;
        changed = (seg_in != seg_q);
        if (changed) begin
            run_len_d = 8'd1;
        end else if (run_len_q >= STABLE_LIM) begin
            run_len_d = STABLE_LIM;
        end else begin
            run_len_d = run_len_q + 8'd1;
        end
        accept  = (run_len_d == STABLE_LIM) && (changed || (run_len_q != STABLE_LIM));
        pattern = seg_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q     <= 7'd0;
            run_len_q <= 8'd0;
        end else begin
            seg_q     <= seg_d;
            run_len_q <= run_len_d;
        end
    end

endmodule

// File: rtl/seg_word_checker.sv
// rtl/seg_word_checker.sv - decodes filtered segment patterns and tracks the expected word
module seg_word_checker
    import seg_word_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int WORD_LEN      = seg_word_pkg::WORD_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] letter,
    output logic       letter_stb,
    output logic       match,
    output logic [3:0] pos,
    output logic       word_done,
    output logic       seq_err,
    output logic [7:0] word_cnt
);

    localparam logic [3:0] LAST_POS = 4'(WORD_LEN - 1);

    logic       accept;
    logic [6:0] pattern;
    logic [3:0] code;

    state_e     state_q, state_d;
    logic [3:0] letter_q, letter_d;
    logic       letter_stb_q, letter_stb_d;
    logic       match_q, match_d;
    logic [3:0] pos_q, pos_d;
    logic       word_done_q, word_done_d;
    logic       seq_err_q, seq_err_d;
    logic [7:0] word_cnt_q, word_cnt_d;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .seg_in (seg_in),
        .accept (accept),
        .pattern(pattern)
    );

    always_comb begin
        code         = decode_seg(pattern);
        state_d      = state_q;
        letter_d     = letter_q;
        letter_stb_d = 1'b0;
        match_d      = match_q;
        pos_d        = pos_q;
        word_done_d  = 1'b0;
        seq_err_d    = seq_err_q;
        word_cnt_d   = word_cnt_q;

        // Blank is accepted by the filter only to separate repeated letters.
        if (accept && (code != CODE_BLANK)) begin
            letter_d     = code;
            letter_stb_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (code == CODE_S) begin
                        state_d = RUN;
                        pos_d   = 4'd1;
                        match_d = 1'b1;
                    end else begin
                        match_d = 1'b0;
                    end
                end
                RUN: begin
                    if (code == EXP[pos_q]) begin
                        match_d = 1'b1;
                        if (pos_q == LAST_POS) begin
                            word_done_d = 1'b1;
                            if (word_cnt_q != 8'hFF) begin
                                word_cnt_d = word_cnt_q + 8'd1;
                            end
                            pos_d   = 4'd0;
                            state_d = IDLE;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        match_d   = 1'b0;
                        seq_err_d = 1'b1;
                        pos_d     = 4'd0;
                        state_d   = ERR;
                    end
                end
                ERR: begin
                    if (code == CODE_S) begin
                        seq_err_d = 1'b0;
                        state_d   = RUN;
                        pos_d     = 4'd1;
                        match_d   = 1'b1;
                    end else begin
                        match_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pos_d   = 4'd0;
                    match_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            letter_q     <= 4'd0;
            letter_stb_q <= 1'b0;
            match_q      <= 1'b0;
            pos_q        <= 4'd0;
            word_done_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            word_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            letter_q     <= letter_d;
            letter_stb_q <= letter_stb_d;
            match_q      <= match_d;
            pos_q        <= pos_d;
            word_done_q  <= word_done_d;
            seq_err_q    <= seq_err_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign letter     = letter_q;
    assign letter_stb = letter_stb_q;
    assign match      = match_q;
    assign pos        = pos_q;
    assign word_done  = word_done_q;
    assign seq_err    = seq_err_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_seg_word_checker.sv
// tb/tb_seg_word_checker.sv - scoreboard bench for seg_word_checker
module tb_seg_word_checker;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'd0;
    logic [3:0] letter;
    logic       letter_stb;
    logic       match;
    logic [3:0] pos;
    logic       word_done;
    logic       seq_err;
    logic [7:0] word_cnt;

    always #5 clk = ~clk;

    seg_word_checker #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .letter    (letter),
        .letter_stb(letter_stb),
        .match     (match),
        .pos       (pos),
        .word_done (word_done),
        .seq_err   (seq_err),
        .word_cnt  (word_cnt)
    );

    typedef struct packed {
        logic [3:0] letter;
        logic       match;
        logic [3:0] pos;
        logic       word_done;
        logic       seq_err;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int stb_count = 0;

    logic [3:0] word_codes [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                    4'd5, 4'd6, 4'd4, 4'd3, 4'd7, 4'd5};

    int         m_state;
    int         m_pos;
    int         m_cnt;
    logic       m_err;
    logic [6:0] last_pat;
    int         run_cnt;

    function automatic logic [6:0] pat_of(input logic [3:0] c);
        case (c)
            4'd1:    return 7'b1011011;
            4'd2:    return 7'b1001111;
            4'd3:    return 7'b0010101;
            4'd4:    return 7'b1111110;
            4'd5:    return 7'b0001110;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b0111110;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] tb_decode(input logic [6:0] p);
        if (p == 7'd0) return 4'd0;
        for (int c = 1; c <= 7; c++) begin
            if (pat_of(4'(c)) == p) return 4'(c);
        end
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pos   = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_letter(input logic [3:0] code);
        exp_t e;
        e.word_done = 1'b0;
        e.match     = 1'b0;
        case (m_state)
            0: if (code == 4'd1) begin m_state = 1; m_pos = 1; e.match = 1'b1; end
            1: begin
                if (code == word_codes[m_pos]) begin
                    e.match = 1'b1;
                    if (m_pos == 12) begin
                        e.word_done = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                        m_pos = 0;
                        m_state = 0;
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_err = 1'b1; m_pos = 0; m_state = 2;
                end
            end
            default: if (code == 4'd1) begin m_err = 1'b0; m_state = 1; m_pos = 1; e.match = 1'b1; end
        endcase
        e.letter  = code;
        e.pos     = 4'(m_pos);
        e.seq_err = m_err;
        e.cnt     = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [6:0] pat, input int n);
        int old_run;
        bit hit;
        old_run = run_cnt;
        if (pat == last_pat) begin
            run_cnt = old_run + n;
            hit = (old_run < STABLE) && (run_cnt >= STABLE);
        end else begin
            run_cnt = n;
            hit = (n >= STABLE);
        end
        if (run_cnt > 1000) run_cnt = 1000;
        last_pat = pat;
        seg_in = pat;
        if (hit && pat != 7'd0) model_letter(tb_decode(pat));
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input int n_letters, input int cyc);
        for (int i = 0; i < n_letters; i++) drive(pat_of(word_codes[i]), cyc);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending: got %0d strobes outstanding, want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seg_in = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        last_pat = 7'd0;
        run_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (letter_stb) begin
                stb_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got letter=%h pos=%0d, want no strobe", letter, pos);
                end else begin
                    exp_t e;
                    exp_t got;
                    e = exp_q.pop_front();
                    got = {letter, match, pos, word_done, seq_err, word_cnt};
                    if (got !== e) begin
                        errors++;
                        $display("FAIL strobe: got letter=%h match=%b pos=%0d done=%b err=%b cnt=%0d, want letter=%h match=%b pos=%0d done=%b err=%b cnt=%0d",
                                 got.letter, got.match, got.pos, got.word_done, got.seq_err, got.cnt,
                                 e.letter, e.match, e.pos, e.word_done, e.seq_err, e.cnt);
                    end
                end
            end else if (word_done) begin
                checks++;
                errors++;
                $display("FAIL done_without_strobe: got word_done=1, want 0");
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        seg_in = 7'b1011011;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({letter, letter_stb, match, pos, word_done, seq_err, word_cnt} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {letter, letter_stb, match, pos, word_done, seq_err, word_cnt});
        end
        model_reset();
        rst_n = 1'b1;
        model_letter(4'd1);
        repeat (STABLE - 1) @(posedge clk);
        #1;
        checks++;
        if (letter_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_early_strobe: got %b, want 0", letter_stb);
        end
        @(posedge clk);
        #1;
        checks++;
        if (letter_stb !== 1'b1) begin
            errors++;
            $display("FAIL reset_latency: got %b, want 1", letter_stb);
        end
        last_pat = 7'b1011011;
        run_cnt = STABLE + 3;
        repeat (3) @(posedge clk);
        drain("reset");
    endtask

    task automatic test_clean_word();
        int s0;
        do_reset();
        s0 = stb_count;
        drive_word(13, 6);
        drain("clean_word");
        checks++;
        if (stb_count - s0 != 13) begin
            errors++;
            $display("FAIL clean_strobes: got %0d, want 13", stb_count - s0);
        end
        checks++;
        if ({word_cnt, seq_err, pos} !== {8'd1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL clean_final: got cnt=%0d err=%b pos=%0d, want cnt=1 err=0 pos=0", word_cnt, seq_err, pos);
        end
    endtask

    task automatic test_glitch();
        int s0;
        do_reset();
        s0 = stb_count;
        drive_word(5, 6);
        drive(7'b0001110, STABLE - 1);
        drive(pat_of(4'd6), 6);
        drain("glitch");
        checks++;
        if ({pos, seq_err} !== {4'd6, 1'b0} || stb_count - s0 != 6) begin
            errors++;
            $display("FAIL glitch: got pos=%0d err=%b strobes=%0d, want pos=6 err=0 strobes=6", pos, seq_err, stb_count - s0);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        drive(pat_of(4'd1), 6);
        drive(pat_of(4'd2), 6);
        drive(pat_of(4'd4), 6);
        drain("mismatch_o");
        checks++;
        if ({seq_err, pos, match} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mismatch_err: got err=%b pos=%0d match=%b, want err=1 pos=0 match=0", seq_err, pos, match);
        end
        drive(pat_of(4'd2), 6);
        drain("mismatch_e");
        checks++;
        if (seq_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_sticky: got err=%b, want 1", seq_err);
        end
        drive(pat_of(4'd1), 6);
        drain("mismatch_s");
        checks++;
        if ({seq_err, pos} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL mismatch_recover: got err=%b pos=%0d, want err=0 pos=1", seq_err, pos);
        end
    endtask

    task automatic test_unknown_blank();
        int s0;
        do_reset();
        drive(7'b1111111, 6);
        drain("unknown_idle");
        checks++;
        if ({letter, seq_err} !== {4'hF, 1'b0}) begin
            errors++;
            $display("FAIL unknown_idle: got letter=%h err=%b, want letter=f err=0", letter, seq_err);
        end
        drive_word(3, 6);
        drive(7'b1111111, 6);
        drain("unknown_run");
        checks++;
        if (seq_err !== 1'b1) begin
            errors++;
            $display("FAIL unknown_run: got err=%b, want 1", seq_err);
        end
        do_reset();
        s0 = stb_count;
        drive_word(5, 6);
        drive(7'b0000000, 6);
        drive(7'b0001110, 6);
        drain("blank_split");
        checks++;
        if ({seq_err, letter} !== {1'b1, 4'd5} || stb_count - s0 != 6) begin
            errors++;
            $display("FAIL blank_split: got err=%b letter=%h strobes=%0d, want err=1 letter=5 strobes=6", seq_err, letter, stb_count - s0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int w = 0; w < 256; w++) drive_word(13, STABLE);
        drain("saturation");
        checks++;
        if (word_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturation: got cnt=%0d, want 255", word_cnt);
        end
        drive_word(7, STABLE);
        drain("pre_reset");
        checks++;
        if (pos !== 4'd7) begin
            errors++;
            $display("FAIL pre_reset_pos: got %0d, want 7", pos);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (word_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_word_done: got %b, want 0", word_done);
            end
        end
        checks++;
        if ({pos, word_cnt} !== {4'd0, 8'd0}) begin
            errors++;
            $display("FAIL mid_word_reset: got pos=%0d cnt=%0d, want 0 0", pos, word_cnt);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        last_pat = 7'd0;
        run_cnt = 0;
        test_reset();
        test_clean_word();
        test_glitch();
        test_mismatch();
        test_unknown_blank();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
